btn_cmd_capture: RTL and testbench
==================================

Name: btn_cmd_capture

Overview:
- Front-end stage for the ALU test wrapper. It produces the `en` / `sel` / `x` command that the wrapper consumes.
- Takes a raw push-button and raw slide switches, synchronizes the button and debounces it.
- Emits exactly one single-cycle `en` pulse per accepted press.
- Presents the `sel`/`x` values, captured at the moment of acceptance, stable alongside that pulse and held afterwards.

Parameters:
- DB_CYCLES, 1000000, stable-level cycles required to accept a press or release (10 ms at 100 MHz); must be >= 2.
- REPEAT_CYCLES, 50000000, hold interval between repeat pulses (used only with BTN_AUTO_REPEAT_EN); must be >= 2.
- SEL_W, 2, width of selector field.
- DATA_W, 6, width of data field.

Ports:
- clk  input  1  system clock, all state on rising edge
- rstn  input  1  asynchronous active-low reset
- btn  input  1  raw asynchronous push-button, active high
- sw_sel  input  SEL_W  raw selector switches (quasi-static)
- sw_x  input  DATA_W  raw data switches (quasi-static)
- en  output  1  one-cycle command strobe
- sel  output  SEL_W  captured selector
- x  output  DATA_W  captured data
- btn_level  output  1  debounced button level

Behaviour:
- Interface (fixed): one clock `clk`; reset `rstn` is asynchronous, active-low.
- Reset values: all outputs 0, state IDLE, all counters 0, synchronizer flops 0.
- Synchronizer:
  - `btn` passes through 2 flops, s1 then s2; the FSM sees only s2.
  - `sw_sel`/`sw_x` are not synchronized; they are sampled directly at capture.
- Debounce counter: width $clog2(DB_CYCLES). Counter values used below: DB_CYCLES-1 is the acceptance terminal count.
- FSM states and transitions:
  - IDLE: s2=1 -> PRESS_WAIT, cnt<=0.
  - PRESS_WAIT:
    - s2=0 -> IDLE (glitch rejected, no pulse).
    - s2=1 and cnt==DB_CYCLES-1 -> HELD, en<=1, sel<=sw_sel, x<=sw_x.
    - otherwise cnt++.
  - HELD: s2=0 -> RELEASE_WAIT, cnt<=0.
  - RELEASE_WAIT:
    - s2=1 -> HELD (no pulse).
    - s2=0 and cnt==DB_CYCLES-1 -> IDLE.
    - otherwise cnt++.
- en:
  - Registered; high for exactly one cycle, then 0 the next cycle unless a repeat fires.
  - Never two pulses without an intervening return to IDLE, except auto-repeat.
- Latency: if btn rises before edge k and stays high, en is high during the cycle following edge k+2+DB_CYCLES.
- sel/x:
  - Update only on edges where en is set.
  - Hold their value otherwise, including after release.
- btn_level: 1 iff state is HELD or RELEASE_WAIT; registered with the state.
- Boundary conditions:
  - Bounce shorter than DB_CYCLES in either direction is absorbed.
  - Release bounce never generates a pulse.
  - Reset asserted mid-press: immediate clear, no pulse issued.
  - Button held through reset release: treated as a fresh press (IDLE -> PRESS_WAIT), exactly one pulse.
  - Switch change in the same cycle as acceptance: the value present at that edge is captured.

Optional Feature:
- Macro: BTN_AUTO_REPEAT_EN.
- Defined:
  - Repeat counter (width $clog2(REPEAT_CYCLES)) clears on entry to HELD and increments each cycle in HELD.
  - At REPEAT_CYCLES-1 it issues en<=1, recaptures sel/x, and clears.
  - Cleared whenever state is not HELD; a release-bounce return to HELD restarts the interval.
- Undefined:
  - No repeat counter logic present.
  - One pulse per press regardless of hold time.

Test Plan (DB_CYCLES=4, REPEAT_CYCLES=8):
- Clean press, sw_sel=2'b01, sw_x=6'h2A, btn high from edge 10 -> en=1 for exactly the cycle after edge 16; sel=01, x=2A thereafter; btn_level=1.
- Bounce btn high 2 cycles / low 1 / high 2 / low -> no en, btn_level stays 0, sel/x unchanged.
- After acceptance, release with 3-cycle bounces, then stable low -> no extra en; btn_level returns to 0 DB_CYCLES+2 cycles after the final fall.
- rstn pulsed low while in PRESS_WAIT with btn held, then released -> outputs 0 immediately; exactly one en pulse DB_CYCLES+2 cycles after rstn rises.
- Two separate presses with sw_x 6'h05 then 6'h3F -> two single-cycle pulses; x=05 then 3F; sel/x stable between.
- With BTN_AUTO_REPEAT_EN, hold btn 40 cycles after acceptance -> additional en pulses every 8 cycles (5 repeats), each recapturing current sw_x. Without the macro -> only one pulse.

Source files
------------

// File: rtl/btn_cmd_capture.sv
// btn_cmd_capture: synchronize + debounce a push-button and issue one
// en strobe per accepted press, with sel/x captured from the switches.
//
// Ports:
//   clk        system clock, all state on rising edge
//   rstn       asynchronous active-low reset
//   btn        raw asynchronous push-button, active high
//   sw_sel     raw selector switches (sampled at capture)
//   sw_x       raw data switches (sampled at capture)
//   en         one-cycle command strobe
//   sel        captured selector, held between strobes
//   x          captured data, held between strobes
//   btn_level  debounced button level (HELD or RELEASE_WAIT)
//
// Optional feature macro: BTN_AUTO_REPEAT_EN
//   When defined, a held button re-issues en (with fresh sel/x)
//   every REPEAT_CYCLES cycles while in HELD.
module btn_cmd_capture #(
  parameter int DB_CYCLES     = 1000000,
  parameter int REPEAT_CYCLES = 50000000,
  parameter int SEL_W         = 2,
  parameter int DATA_W        = 6
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              btn,
  input  logic [SEL_W-1:0]  sw_sel,
  input  logic [DATA_W-1:0] sw_x,
  output logic              en,
  output logic [SEL_W-1:0]  sel,
  output logic [DATA_W-1:0] x,
  output logic              btn_level
);

  localparam int CNT_W =
    ($clog2(DB_CYCLES) < 1) ? 1 : $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] DB_LAST =
    CNT_W'(DB_CYCLES - 1);

  if (DB_CYCLES < 2) begin : g_bad_db
    $error("DB_CYCLES must be >= 2");
  end
  if (REPEAT_CYCLES < 2) begin : g_bad_rpt
    $error("REPEAT_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              s1;
  logic              s2;

`ifdef BTN_AUTO_REPEAT_EN
  localparam int RPT_W =
    ($clog2(REPEAT_CYCLES) < 1) ? 1 : $clog2(REPEAT_CYCLES);
  localparam logic [RPT_W-1:0] RPT_LAST =
    RPT_W'(REPEAT_CYCLES - 1);
  logic [RPT_W-1:0]  rpt;
`endif

  // Two-flop synchronizer; only s2 is seen by the FSM.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      en        <= 1'b0;
      sel       <= '0;
      x         <= '0;
      btn_level <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
      rpt       <= '0;
`endif
    end else begin
      en <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
      // Interval only runs while HELD; any exit restarts it.
      if (state != HELD) rpt <= '0;
`endif
      unique case (state)
        IDLE: begin
          if (s2) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!s2) begin
            state <= IDLE;
          end else if (cnt == DB_LAST) begin
            state     <= HELD;
            btn_level <= 1'b1;
            en        <= 1'b1;
            sel       <= sw_sel;
            x         <= sw_x;
`ifdef BTN_AUTO_REPEAT_EN
            rpt       <= '0;
`endif
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        HELD: begin
          if (!s2) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
`ifdef BTN_AUTO_REPEAT_EN
            rpt   <= '0;
          end else if (rpt == RPT_LAST) begin
            en  <= 1'b1;
            sel <= sw_sel;
            x   <= sw_x;
            rpt <= '0;
          end else begin
            rpt <= rpt + RPT_W'(1);
`endif
          end
        end
        RELEASE_WAIT: begin
          if (s2) begin
            // Release bounce: back to HELD silently.
            state <= HELD;
          end else if (cnt == DB_LAST) begin
            state     <= IDLE;
            btn_level <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          btn_level <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_cmd_capture.sv
// tb_btn_cmd_capture: directed stimulus with a scoreboard queue of
// expected en pulses (edge, sel, x) checked by a separate monitor.
module tb_btn_cmd_capture;

  logic       clk;
  logic       rstn;
  logic       btn;
  logic [1:0] sw_sel;
  logic [5:0] sw_x;
  logic       en;
  logic [1:0] sel;
  logic [5:0] x;
  logic       btn_level;

  typedef struct {
    int         cyc;
    logic [1:0] sel;
    logic [5:0] x;
  } exp_t;

  exp_t q[$];
  int   ecnt   = 0;
  int   checks = 0;
  int   errors = 0;
  int   t0;

  btn_cmd_capture #(
    .DB_CYCLES    (4),
    .REPEAT_CYCLES(8),
    .SEL_W        (2),
    .DATA_W       (6)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .btn      (btn),
    .sw_sel   (sw_sel),
    .sw_x     (sw_x),
    .en       (en),
    .sel      (sel),
    .x        (x),
    .btn_level(btn_level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int c, input logic [1:0] s,
                      input logic [5:0] d);
    exp_t e;
    e.cyc = c;
    e.sel = s;
    e.x   = d;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h, required %0h",
               name, ecnt, act, req);
    end
  endtask

  // Monitor: every en must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rstn === 1'b1 && en !== 1'b0) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_en at edge %0d sel %b x %h",
                 ecnt, sel, x);
      end else begin
        e = q.pop_front();
        if (e.cyc != ecnt || e.sel !== sel || e.x !== x) begin
          errors++;
          $display("FAIL en_pulse: got edge %0d sel %b x %h, required edge %0d sel %b x %h",
                   ecnt, sel, x, e.cyc, e.sel, e.x);
        end
      end
    end
  end

  initial begin
    rstn   = 1'b0;
    btn    = 1'b0;
    sw_sel = 2'b00;
    sw_x   = 6'h00;
    step(3);
    chk("reset_en", 32'(en), 0);
    chk("reset_sel", 32'(sel), 0);
    chk("reset_x", 32'(x), 0);
    chk("reset_level", 32'(btn_level), 0);
    rstn = 1'b1;
    step(3);

    // Clean press, long hold, bouncy release.
    sw_sel = 2'b01;
    sw_x   = 6'h2A;
    btn    = 1'b1;
    t0     = ecnt;
    push(t0 + 7, 2'b01, 6'h2A);
`ifdef BTN_AUTO_REPEAT_EN
    push(t0 + 15, 2'b01, 6'h2A);
    for (int i = 2; i <= 5; i++)
      push(t0 + 7 + 8 * i, 2'b01, 6'h11);
`endif
    step(6);
    chk("level_before_accept", 32'(btn_level), 0);
    step(1);
    chk("level_accept", 32'(btn_level), 1);
    step(13);
    sw_x = 6'h11;
    step(26);
    btn = 1'b0;
    step(3);
    btn = 1'b1;
    step(2);
    chk("level_rel_bounce", 32'(btn_level), 1);
    step(1);
    btn = 1'b0;
    step(6);
    chk("level_rel_wait", 32'(btn_level), 1);
    step(1);
    chk("level_released", 32'(btn_level), 0);
    chk("sel_after_press1", 32'(sel), 32'h1);
`ifdef BTN_AUTO_REPEAT_EN
    chk("x_after_press1", 32'(x), 32'h11);
`else
    chk("x_after_press1", 32'(x), 32'h2A);
`endif

    // Press bounce shorter than the debounce window.
    sw_x   = 6'h33;
    sw_sel = 2'b10;
    step(3);
    btn = 1'b1;
    step(2);
    btn = 1'b0;
    step(1);
    btn = 1'b1;
    step(2);
    btn = 1'b0;
    step(1);
    chk("level_bounce_mid", 32'(btn_level), 0);
    step(8);
    chk("level_bounce_end", 32'(btn_level), 0);
    chk("sel_bounce_hold", 32'(sel), 32'h1);
`ifdef BTN_AUTO_REPEAT_EN
    chk("x_bounce_hold", 32'(x), 32'h11);
`else
    chk("x_bounce_hold", 32'(x), 32'h2A);
`endif

    // Reset in PRESS_WAIT with button held through release.
    sw_sel = 2'b11;
    sw_x   = 6'h0C;
    step(2);
    btn = 1'b1;
    step(4);
    rstn = 1'b0;
    #1;
    chk("midreset_en", 32'(en), 0);
    chk("midreset_level", 32'(btn_level), 0);
    chk("midreset_sel", 32'(sel), 0);
    chk("midreset_x", 32'(x), 0);
    step(2);
    rstn = 1'b1;
    t0   = ecnt;
    push(t0 + 7, 2'b11, 6'h0C);
    step(6);
    chk("post_reset_wait", 32'(btn_level), 0);
    step(1);
    chk("post_reset_accept", 32'(btn_level), 1);
    step(1);
    btn = 1'b0;
    step(10);
    chk("post_reset_release", 32'(btn_level), 0);

    // Two presses; second one changes sw_x on the accept edge.
    sw_sel = 2'b10;
    sw_x   = 6'h05;
    btn    = 1'b1;
    t0     = ecnt;
    push(t0 + 7, 2'b10, 6'h05);
    step(9);
    btn = 1'b0;
    step(10);
    chk("sel_between", 32'(sel), 32'h2);
    chk("x_between", 32'(x), 32'h05);
    sw_sel = 2'b01;
    sw_x   = 6'h15;
    btn    = 1'b1;
    t0     = ecnt;
    push(t0 + 7, 2'b01, 6'h3F);
    step(6);
    sw_x = 6'h3F;
    step(1);
    chk("x_same_edge", 32'(x), 32'h3F);
    step(2);
    btn = 1'b0;
    step(12);
    chk("sel_final", 32'(sel), 32'h1);
    chk("x_final", 32'(x), 32'h3F);
    chk("level_final", 32'(btn_level), 0);

    step(5);
    chk("pending_pulses", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
